// File: rtl/aud_pkg.sv
// Shared types and constants for the WM8731 I2S playback path.
package aud_pkg;

  typedef enum logic {S_IDLE, S_SEND} player_state_t;

  localparam int AUD_DATA_W        = 16;
  localparam int AUD_BITS_PER_WORD = 16;

endpackage

// File: rtl/aud_gain.sv
// Combinational mute and attenuation: the sample is arithmetically shifted right,
// so it can never overflow and no saturation stage is needed.
module aud_gain
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W
) (
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     mute,
  input  logic        [2:0]        vol_shift,
  output logic signed [DATA_W-1:0] scaled
);

  always_comb begin
    scaled = '0;
    if (!mute) scaled = sample >>> vol_shift;
  end

endmodule

// File: rtl/aud_player.sv
// I2S serializer for the WM8731 DACDAT line, clocked by BCLK (one cycle per bit slot).
// Optional AUD_PLAYER_STEREO_DUP_EN repeats the last left sample in the right slot.
//
// state  | meaning
// S_IDLE | line held at 0, waiting for a DACLRCK edge
// S_SEND | shifting the captured word out MSB-first
module aud_player
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W,
  parameter int FCNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_daclrck,
  input  logic signed [DATA_W-1:0] i_dac_data,
  input  logic                     i_mute,
  input  logic        [2:0]        i_vol_shift,
  output logic                     o_aud_dacdat,
  output logic                     o_busy,
  output logic                     o_frame_pulse,
  output logic        [FCNT_W-1:0] o_frame_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  player_state_t state, state_n;

  logic [DATA_W-1:0] shift_r, shift_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [FCNT_W-1:0] fcnt_n;
  logic              lrck_d;
  logic              fall;
  logic              dacdat_n, busy_n, pulse_n;
  logic signed [DATA_W-1:0] scaled;

`ifdef AUD_PLAYER_STEREO_DUP_EN
  logic [DATA_W-1:0] hold_r, hold_n;
  logic              rise;
  assign rise = ~lrck_d & i_daclrck;
`endif

  // lrck_d resets low so a DACLRCK already low at reset release is not an edge.
  assign fall = lrck_d & ~i_daclrck;

  aud_gain #(.DATA_W(DATA_W)) u_gain (
    .sample    (i_dac_data),
    .mute      (i_mute),
    .vol_shift (i_vol_shift),
    .scaled    (scaled)
  );

  always_comb begin
    state_n   = state;
    shift_n   = shift_r;
    bit_cnt_n = bit_cnt;
    fcnt_n    = o_frame_cnt;
    dacdat_n  = 1'b0;
    busy_n    = o_busy;
    pulse_n   = 1'b0;
`ifdef AUD_PLAYER_STEREO_DUP_EN
    hold_n    = hold_r;
`endif

    if (fall) begin
      // A left-slot edge always wins, abandoning any word still in flight.
      if (i_en) begin
        dacdat_n  = scaled[DATA_W-1];
        shift_n   = {scaled[DATA_W-2:0], 1'b0};
        bit_cnt_n = CNT_W'(1);
        busy_n    = 1'b1;
        pulse_n   = 1'b1;
        fcnt_n    = o_frame_cnt + FCNT_W'(1);
        state_n   = S_SEND;
`ifdef AUD_PLAYER_STEREO_DUP_EN
        hold_n    = scaled;
`endif
      end else begin
        bit_cnt_n = '0;
        busy_n    = 1'b0;
        state_n   = S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          busy_n = 1'b0;
`ifdef AUD_PLAYER_STEREO_DUP_EN
          if (rise) begin
            dacdat_n  = hold_r[DATA_W-1];
            shift_n   = {hold_r[DATA_W-2:0], 1'b0};
            bit_cnt_n = CNT_W'(1);
            busy_n    = 1'b1;
            state_n   = S_SEND;
          end
`endif
        end
        S_SEND: begin
          if (bit_cnt < CNT_W'(DATA_W)) begin
            dacdat_n  = shift_r[DATA_W-1];
            shift_n   = {shift_r[DATA_W-2:0], 1'b0};
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end else begin
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            state_n   = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      shift_r       <= '0;
      bit_cnt       <= '0;
      lrck_d        <= 1'b0;
      o_aud_dacdat  <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_pulse <= 1'b0;
      o_frame_cnt   <= '0;
`ifdef AUD_PLAYER_STEREO_DUP_EN
      hold_r        <= '0;
`endif
    end else begin
      state         <= state_n;
      shift_r       <= shift_n;
      bit_cnt       <= bit_cnt_n;
      lrck_d        <= i_daclrck;
      o_aud_dacdat  <= dacdat_n;
      o_busy        <= busy_n;
      o_frame_pulse <= pulse_n;
      o_frame_cnt   <= fcnt_n;
`ifdef AUD_PLAYER_STEREO_DUP_EN
      hold_r        <= hold_n;
`endif
    end
  end

endmodule

// File: tb/tb_aud_player.sv
// Scoreboard bench for aud_player: stimulus pushes expected words, a monitor
// collects DACDAT words and compares. Honours AUD_PLAYER_STEREO_DUP_EN.
module tb_aud_player;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_en;
  logic               i_daclrck;
  logic signed [15:0] i_dac_data;
  logic               i_mute;
  logic        [2:0]  i_vol_shift;
  logic               o_aud_dacdat;
  logic               o_busy;
  logic               o_frame_pulse;
  logic        [15:0] o_frame_cnt;

  aud_player #(.DATA_W(16), .FCNT_W(16)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_daclrck     (i_daclrck),
    .i_dac_data    (i_dac_data),
    .i_mute        (i_mute),
    .i_vol_shift   (i_vol_shift),
    .o_aud_dacdat  (o_aud_dacdat),
    .o_busy        (o_busy),
    .o_frame_pulse (o_frame_pulse),
    .o_frame_cnt   (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] word;
    logic        pulse;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;
  logic [15:0] last_left = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference gain: floor division by 2^s on the signed value, or 0 when muted.
  function automatic logic [15:0] model(input logic [15:0] d, input bit m, input int s);
    int v, p, q;
    if (m) return 16'h0000;
    v = int'($signed(d));
    p = 1 << s;
    if (v >= 0) q = v / p;
    else        q = -((-v + p - 1) / p);
    return q[15:0];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic right_slot();
    i_daclrck = 1'b1;
    i_en      = 1'b0;
`ifdef AUD_PLAYER_STEREO_DUP_EN
    exp_q.push_back('{last_left, 1'b0, 16'(exp_cnt)});
`endif
    repeat (32) tick();
  endtask

  task automatic left_slot(input bit en, input logic [15:0] d, input bit m, input logic [2:0] s);
    i_daclrck   = 1'b0;
    i_en        = en;
    i_dac_data  = d;
    i_mute      = m;
    i_vol_shift = s;
    if (en) begin
      exp_cnt++;
      last_left = model(d, m, int'(s));
      exp_q.push_back('{last_left, 1'b1, 16'(exp_cnt)});
    end
    tick();
    for (int i = 0; i < 31; i++) begin
      if (i == 3) begin
        // Mid-word changes must not disturb the word in flight.
        i_dac_data  = 16'($urandom);
        i_mute      = 1'($urandom);
        i_vol_shift = 3'($urandom);
      end
      tick();
    end
  endtask

  // Monitor: pops one expectation per word seen on the line.
  initial begin
    exp_t        e;
    logic [15:0] w;
    bit          busy_ok;
    forever begin
      @(negedge i_clk);
      if (mon_en && o_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
          repeat (17) @(negedge i_clk);
        end else begin
          e = exp_q.pop_front();
          chk("word_pulse", 32'(o_frame_pulse), 32'(e.pulse));
          chk("word_cnt", 32'(o_frame_cnt), 32'(e.cnt));
          w = '0;
          busy_ok = 1'b1;
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge i_clk);
            w = {w[14:0], o_aud_dacdat};
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (k == 1) chk("pulse_width", 32'(o_frame_pulse), 32'd0);
          end
          chk("word_bits", 32'(w), 32'(e.word));
          chk("busy_span", 32'(busy_ok), 32'd1);
          @(negedge i_clk);
          chk("word_end_dat", 32'(o_aud_dacdat), 32'd0);
          chk("word_end_busy", 32'(o_busy), 32'd0);
        end
      end else if (mon_en) begin
        chk("idle_dat", 32'(o_aud_dacdat), 32'd0);
        chk("idle_pulse", 32'(o_frame_pulse), 32'd0);
      end
    end
  end

  initial begin
    logic [15:0] d1, d2, w;
    int          c0;
    i_rst_n     = 1'b0;
    i_daclrck   = 1'b0;
    i_en        = 1'b1;
    i_dac_data  = '0;
    i_mute      = 1'b0;
    i_vol_shift = '0;

    repeat (3) tick();
    chk("rst_dat", 32'(o_aud_dacdat), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pulse", 32'(o_frame_pulse), 32'd0);
    chk("rst_cnt", 32'(o_frame_cnt), 32'd0);

    // DACLRCK low through reset release: no frame without a falling edge.
    i_rst_n = 1'b1;
    repeat (12) begin
      tick();
      chk("no_frame_after_rst", 32'(o_busy), 32'd0);
    end
    chk("no_frame_cnt", 32'(o_frame_cnt), 32'd0);

    mon_en = 1'b1;
    right_slot(); left_slot(1'b1, 16'hA5C3, 1'b0, 3'd0);
    right_slot(); left_slot(1'b1, 16'h8000, 1'b0, 3'd3);
    right_slot(); left_slot(1'b1, 16'h7FFF, 1'b0, 3'd7);
    right_slot(); left_slot(1'b1, 16'h1234, 1'b1, 3'd0);
    right_slot(); left_slot(1'b0, 16'h5555, 1'b0, 3'd0);
    chk("en_low_no_count", 32'(o_frame_cnt), 32'(exp_cnt));
    right_slot(); left_slot(1'b1, 16'h0F0F, 1'b0, 3'd0);
    right_slot();

    // Second fall 8 cycles into a word restarts the word immediately.
    mon_en = 1'b0;
    c0 = exp_cnt;
    d1 = 16'($urandom) | 16'h8000;
    d2 = 16'($urandom) & 16'h7FFF;
    i_daclrck = 1'b0; i_en = 1'b1; i_dac_data = d1; i_mute = 1'b0; i_vol_shift = 3'd0;
    tick();
    chk("glitch_first_msb", 32'(o_aud_dacdat), 32'(d1[15]));
    repeat (7) tick();
    i_daclrck = 1'b1; i_en = 1'b0;
    tick();
    i_daclrck = 1'b0; i_en = 1'b1; i_dac_data = d2;
    tick();
    chk("glitch_restart_msb", 32'(o_aud_dacdat), 32'(d2[15]));
    chk("glitch_pulse", 32'(o_frame_pulse), 32'd1);
    chk("glitch_cnt", 32'(o_frame_cnt), 32'(c0 + 2));
    exp_cnt   = c0 + 2;
    last_left = d2;
    w = {15'd0, o_aud_dacdat};
    repeat (15) begin
      tick();
      w = {w[14:0], o_aud_dacdat};
    end
    chk("glitch_word", 32'(w), 32'(d2));
    tick();
    chk("glitch_end_dat", 32'(o_aud_dacdat), 32'd0);
    chk("glitch_end_busy", 32'(o_busy), 32'd0);
    repeat (10) tick();
    mon_en = 1'b1;
    right_slot();

    // Reset pulsed mid-word.
    mon_en = 1'b0;
    i_daclrck = 1'b0; i_en = 1'b1; i_dac_data = 16'hFFFF; i_mute = 1'b0; i_vol_shift = 3'd0;
    tick();
    repeat (5) tick();
    i_rst_n = 1'b0;
    tick();
    chk("midrst_dat", 32'(o_aud_dacdat), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_pulse", 32'(o_frame_pulse), 32'd0);
    chk("midrst_cnt", 32'(o_frame_cnt), 32'd0);
    i_rst_n   = 1'b1;
    exp_cnt   = 0;
    last_left = '0;
    repeat (8) begin
      tick();
      chk("midrst_no_frame", 32'(o_busy), 32'd0);
    end
    mon_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      right_slot();
      left_slot(($urandom % 6) != 0, 16'($urandom), ($urandom % 4) == 0, 3'($urandom % 8));
    end
    right_slot();
    repeat (4) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
